// File: rtl/pc_fetch_seq_pkg.sv
// ---------------------------------------------------------------------------
// pc_fetch_seq_pkg
//   Shared definitions for the PC fetch sequencer:
//     fetch_state_e : fetch FSM encoding (F_REQ -> F_WAIT -> F_DONE)
//     PC_INC        : byte increment for sequential fetch
//     INSTR_W       : instruction width in bits
// ---------------------------------------------------------------------------
package pc_fetch_seq_pkg;

  typedef enum logic [1:0] {
    F_REQ  = 2'd0,  // request on the bus, waiting for imem_req_ready
    F_WAIT = 2'd1,  // request accepted, waiting for imem_rsp_valid
    F_DONE = 2'd2   // instruction captured, waiting for an advance
  } fetch_state_e;

  localparam int unsigned PC_INC  = 4;
  localparam int unsigned INSTR_W = 32;

endpackage

// File: rtl/pc_fetch_seq_redirect_buf.sv
// ---------------------------------------------------------------------------
// pc_redirect_buf
//   One-entry holding register for a redirect target that arrived while the
//   PC could not advance. A newer load overwrites the held target; clear
//   (the advance that consumes the target) wins over load.
//
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     load        : store load_pc as the pending target
//     clear       : drop the pending target
//     load_pc     : target to store
//     pend_valid  : a pending target is held
//     pend_pc     : the held target
// ---------------------------------------------------------------------------
module pc_redirect_buf
  import pc_fetch_seq_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clear,
  input  logic [PC_W-1:0] load_pc,
  output logic            pend_valid,
  output logic [PC_W-1:0] pend_pc
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples its inputs as they were before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else if (clear) begin
      pend_valid <= 1'b0;
    end else if (load) begin
      pend_valid <= 1'b1;
      pend_pc    <= load_pc;
    end
  end

endmodule

// File: rtl/pc_fetch_seq.sv
// ---------------------------------------------------------------------------
// pc_fetch_seq
//   Program-counter register plus a three-state instruction fetch FSM.
//   The PC moves only when the sequencing phase says "next pc" (choose=0)
//   and the current fetch has completed; each move starts a new fetch.
//   Redirects that cannot be applied immediately wait in pc_redirect_buf.
//
//   Build option:
//     PC_MISALIGN_TRAP_EN : misaligned redirects are dropped and flagged on
//                           the misalign output. Without it the port is
//                           absent and redirect bits [1:0] are forced to 00.
//
//   Ports:
//     clk, rst_n                : clock, asynchronous active-low reset
//     choose                    : 0 = next pc phase, 1 = hold pc
//     redirect_valid/_pc        : branch/jump request and target
//     imem_req_valid/_addr      : fetch request to instruction memory
//     imem_req_ready            : memory accepts the request
//     imem_rsp_valid/_data      : fetch response
//     pc                        : current PC
//     instr, instr_valid        : last fetched instruction, capture pulse
//     stall                     : advance wanted but fetch not finished
//     misalign                  : (option only) misaligned redirect dropped
// ---------------------------------------------------------------------------
module pc_fetch_seq
  import pc_fetch_seq_pkg::*;
#(
  parameter int          PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               choose,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req_valid,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               stall
`ifdef PC_MISALIGN_TRAP_EN
 ,output logic               misalign
`endif
);

  fetch_state_e    state, state_next;
  logic            advance;
  logic            redir_ok;
  logic [PC_W-1:0] redir_target;
  logic [PC_W-1:0] pc_next;
  logic            pend_valid;
  logic [PC_W-1:0] pend_pc;

  // ---- redirect qualification --------------------------------------------
`ifdef PC_MISALIGN_TRAP_EN
  assign redir_ok     = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign redir_target = redirect_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign <= 1'b0;
    else        misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
  end
`else
  assign redir_ok     = redirect_valid;
  assign redir_target = redirect_pc & ~PC_W'(3);
`endif

  // ---- advance and next PC -----------------------------------------------
  assign advance = !choose && (state == F_DONE);
  assign stall   = !choose && (state != F_DONE);

  // A redirect seen on the advancing edge is newer than anything pending.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    pc_next = pc + PC_W'(PC_INC);
    if (redir_ok)        pc_next = redir_target;
    else if (pend_valid) pc_next = pend_pc;
  end

  pc_redirect_buf #(
    .PC_W (PC_W)
  ) u_redirect_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (redir_ok && !advance),
    .clear      (advance),
    .load_pc    (redir_target),
    .pend_valid (pend_valid),
    .pend_pc    (pend_pc)
  );

  // ---- fetch FSM ---------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      F_REQ:   if (imem_req_ready) state_next = F_WAIT;
      F_WAIT:  if (imem_rsp_valid) state_next = F_DONE;
      F_DONE:  if (advance)        state_next = F_REQ;
      default:                     state_next = F_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= F_REQ;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_next;
      instr_valid <= 1'b0;
      if (advance) pc <= pc_next;
      if (state == F_WAIT && imem_rsp_valid) begin
        instr       <= imem_rsp_data;
        instr_valid <= 1'b1;
      end
    end
  end

  // Reset forces F_REQ, so the request is also gated by rst_n to keep the
  // bus quiet until reset is released.
  assign imem_req_valid = (state == F_REQ) && rst_n;
  assign imem_req_addr  = pc;

endmodule
